controle_fsm: RTL
=================

# controle_fsm

Control unit of the sequence-memory game. It consumes the datapath status flags (`end_fpga`, `end_user`, `end_time`, `win`, `match`) and an operator `enter` request, and drives the datapath command lines (`r1`, `r2`, `e1`–`e4`, `sel`). It sits beside the datapath at top level and closes the command/status loop: commands go out, status comes back. It is a Moore machine, with a local synchronizer and edge detector on `enter`.

## Interface
- No parameters. State encoding is fixed, 4 bits: INIT=0, SETUP=1, PREP=2, PLAY_FPGA=3, PLAY_USER=4, CHECK_USER=5, NEXT_ROUND=6, CHECK_WIN=7, RESULT=8.
- `clock_50`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  asynchronous, active-high; forces INIT.
- `enter`  in  1  operator confirm, active-high level from the board key.
- `end_fpga`  in  1  FPGA sequence display finished.
- `end_user`  in  1  user entered as many symbols as the current round.
- `end_time`  in  1  user entry timeout.
- `win`  in  1  round counter reached its terminal count.
- `match`  in  1  user sequence equals FPGA sequence; qualified by `end_user` inside the datapath.
- `r1`  out  1  global datapath reset (setup register, round counter, clock divider).
- `r2`  out  1  per-round reset (user, time, FPGA counters and registers).
- `e1`  out  1  setup register load enable.
- `e2`  out  1  user entry and time counting enable.
- `e3`  out  1  FPGA sequence playback enable.
- `e4`  out  1  round counter increment.
- `sel`  out  1  display select: 1 = level/time/round, 0 = result message.
- `state`  out  4  current state code, for debug and LEDs.

## Operation
- Outputs are decoded from the state register only; there are no input-to-output paths.
- INIT: `r1`=1, `r2`=1, `sel`=1. Moves to SETUP unconditionally.
- SETUP: `e1`=1, `sel`=1. On an `enter` pulse, moves to PREP.
- PREP: `r2`=1, `sel`=1. Moves to PLAY_FPGA unconditionally.
- PLAY_FPGA: `e3`=1, `sel`=1. On `end_fpga`, moves to PLAY_USER.
- PLAY_USER: `e2`=1, `sel`=1.
  - `end_time`: moves to RESULT.
  - `end_user` without `end_time`: moves to CHECK_USER.
  - Both high in the same cycle: `end_time` wins and the game is lost.
- CHECK_USER: `sel`=1. `match`=1 moves to NEXT_ROUND; `match`=0 moves to RESULT.
- NEXT_ROUND: `e4`=1 for exactly one cycle, `sel`=1. Moves to CHECK_WIN.
- CHECK_WIN: `sel`=1. Samples `win` after the increment has settled. `win`=1 moves to RESULT; otherwise moves to PREP.
- RESULT: `sel`=0; the datapath shows the win or fail message. On an `enter` pulse, moves to INIT.
- Every output not listed for a state is 0.
- An unused state code (9–15) moves to INIT on the next edge, with all outputs 0 except `sel`=1.

## Timing
- Reset is asynchronous. While it is asserted: state=INIT, so `r1`=`r2`=`sel`=1, `e1`–`e4`=0, and `state`=0.
- The `enter` synchronizer flops reset to 1. A key held through reset release therefore produces no pulse until it is released and pressed again.
- One state transition per rising edge. Each output changes in the same cycle as `state`.
- The `enter` pulse is exactly one cycle per rising edge of `enter`, however long the key is held.
- Status inputs are sampled on the edge that ends the cycle. Latency from a status flag to the new command is 1 clock.
- Minimum round loop (PREP → PLAY_FPGA → PLAY_USER → CHECK_USER → NEXT_ROUND → CHECK_WIN → PREP) is 6 clocks, not counting the time spent waiting in the play states.
- An `enter` pulse in any state other than SETUP or RESULT is ignored and not queued.

## Configuration
- `ENTER_SYNC_EN` defined: `enter` passes through two synchronizer flops and a rising-edge detector. A rise on `enter` changes state on the 3rd rising edge of `clock_50` after it.
- Not defined: `enter` is used directly as the pulse. It must already be a synchronized single-cycle pulse, e.g. from the button synchronizer. The state changes on the 1st edge where `enter`=1. Each cycle of a held level counts as a separate pulse.

## Test plan
- Reset: assert `reset` mid-PLAY_USER → `state`=0, `r1`=`r2`=1, `e2`=0 immediately, without waiting for a clock; release → `state`=1 one edge later.
- Happy round, with `ENTER_SYNC_EN`: in SETUP raise `enter` for 10 cycles → exactly one PREP entry, 3 edges after the rise. Then pulse `end_fpga`, raise `end_user` with `match`=1, `win`=0 → `e4` high for exactly 1 cycle, then `state`=2.
- Win: same sequence with `win`=1 in CHECK_WIN → `state`=8, `sel`=0. An `enter` pulse then gives `state`=0.
- Mismatch: `end_user`=1, `match`=0 → CHECK_USER then RESULT; `e4` never asserts.
- Simultaneous flags: `end_time`=1 and `end_user`=1 in the same PLAY_USER cycle → next state=8, CHECK_USER never visited.
- Ignored enter and illegal state: an `enter` pulse during PLAY_FPGA gives no transition. A state register forced to 12 gives `state`=0 on the next edge.

Source files
------------

// File: rtl/controle_fsm.sv
// Moore control unit of the sequence-memory game; define ENTER_SYNC_EN to add a 2-flop synchronizer and rising-edge detector on enter.
// Status flags act on the next clock edge; a synchronized enter acts on the 3rd edge. There is no backpressure: enter outside SETUP/RESULT is dropped.
module controle_fsm (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_fpga,
  input  logic       end_user,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       r1,
  output logic       r2,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       e4,
  output logic       sel,
  output logic [3:0] state
);

  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_SETUP      = 4'd1;
  localparam logic [3:0] S_PREP       = 4'd2;
  localparam logic [3:0] S_PLAY_FPGA  = 4'd3;
  localparam logic [3:0] S_PLAY_USER  = 4'd4;
  localparam logic [3:0] S_CHECK_USER = 4'd5;
  localparam logic [3:0] S_NEXT_ROUND = 4'd6;
  localparam logic [3:0] S_CHECK_WIN  = 4'd7;
  localparam logic [3:0] S_RESULT     = 4'd8;

  logic [3:0] state_q, state_d;
  logic       enter_pulse;

`ifdef ENTER_SYNC_EN
  logic enter_meta_q, enter_meta_d;
  logic enter_sync_q, enter_sync_d;
  logic enter_prev_q, enter_prev_d;

  always_comb begin
    enter_meta_d = enter;
    enter_sync_d = enter_meta_q;
    enter_prev_d = enter_sync_q;
    enter_pulse  = enter_sync_q & ~enter_prev_q;
  end

  // Reset to 1 so a key held through reset release does not look like a fresh press.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      enter_meta_q <= 1'b1;
      enter_sync_q <= 1'b1;
      enter_prev_q <= 1'b1;
    end else begin
      enter_meta_q <= enter_meta_d;
      enter_sync_q <= enter_sync_d;
      enter_prev_q <= enter_prev_d;
    end
  end
`else
  assign enter_pulse = enter;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:       state_d = S_SETUP;
      S_SETUP:      if (enter_pulse) state_d = S_PREP;
      S_PREP:       state_d = S_PLAY_FPGA;
      S_PLAY_FPGA:  if (end_fpga) state_d = S_PLAY_USER;
      // A timeout in the same cycle as the last entry still loses the game.
      S_PLAY_USER: begin
        if (end_time)      state_d = S_RESULT;
        else if (end_user) state_d = S_CHECK_USER;
      end
      S_CHECK_USER: state_d = match ? S_NEXT_ROUND : S_RESULT;
      S_NEXT_ROUND: state_d = S_CHECK_WIN;
      S_CHECK_WIN:  state_d = win ? S_RESULT : S_PREP;
      S_RESULT:     if (enter_pulse) state_d = S_INIT;
      default:      state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    r1  = 1'b0;
    r2  = 1'b0;
    e1  = 1'b0;
    e2  = 1'b0;
    e3  = 1'b0;
    e4  = 1'b0;
    sel = 1'b1;
    case (state_q)
      S_INIT: begin
        r1 = 1'b1;
        r2 = 1'b1;
      end
      S_SETUP:      e1  = 1'b1;
      S_PREP:       r2  = 1'b1;
      S_PLAY_FPGA:  e3  = 1'b1;
      S_PLAY_USER:  e2  = 1'b1;
      S_NEXT_ROUND: e4  = 1'b1;
      S_RESULT:     sel = 1'b0;
      default:      sel = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule
